// File: rtl/sprite_arb_pkg.sv
// Shared types and constants for the sprite frame-buffer arbiter.
package sprite_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } arb_state_t;

    localparam int NREQ_DEF = 4;
    localparam int IDX_W    = 2;

    localparam int REQ_PLAYER      = 0;
    localparam int REQ_PLAYER_SHOT = 1;
    localparam int REQ_ENEMY       = 2;
    localparam int REQ_ENEMY_SHOT  = 3;

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin search: first requesting index after rr_ptr, wrapping modulo NREQ.
module arb_rr_pick
    import sprite_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    int unsigned cand;

    // Scan farthest-to-nearest so the nearest hit after rr_ptr is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = (32'(rr_ptr) + k) % NREQ;
            if (req[cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_bus_arbiter.sv
// Round-robin frame-buffer arbiter for sprite renderers.
// Optional burst preemption is enabled by defining ARB_BURST_LIMIT_EN.
module sprite_bus_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 12,
    parameter int MAX_BURST = 64
) (
    input  logic                   clk,
    input  logic                   hard_reset,
    input  logic                   frame_start,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        wr_en_in,
    input  logic [NREQ*ADDR_W-1:0] wr_addr_in,
    input  logic [NREQ*DATA_W-1:0] wr_data_in,
    output logic [NREQ-1:0]        grant,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   fb_we,
    output logic [ADDR_W-1:0]      fb_addr,
    output logic [DATA_W-1:0]      fb_data,
    output logic [7:0]             drop_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    if (NREQ < 1 || NREQ > 4 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_param_check
        $error("sprite_bus_arbiter: NREQ must be 1..4 and MAX_BURST 1..255");
    end

    arb_state_t       state_q, state_nxt;
    logic [NREQ-1:0]  grant_q, grant_nxt;
    logic [IDX_W-1:0] grant_id_q, grant_id_nxt;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_nxt, pick_ptr;
    logic [7:0]       drop_cnt_q, drop_nxt;
    logic [8:0]       drop_sum;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             burst_hit;

    // A vsync on an arbitration edge restarts the search from requester 0.
    assign pick_ptr = frame_start ? LAST_IDX : rr_ptr_q;

    arb_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .rr_ptr (pick_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

`ifdef ARB_BURST_LIMIT_EN
    logic [7:0] burst_q, burst_nxt;

    assign burst_hit = (burst_q >= 8'(MAX_BURST)) && (|(req & ~grant_q));

    always_comb begin
        burst_nxt = burst_q;
        if (state_nxt == GRANT) begin
            if (state_q != GRANT)
                burst_nxt = 8'd1;
            else if (burst_q != 8'hFF)
                burst_nxt = burst_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset)
            burst_q <= '0;
        else
            burst_q <= burst_nxt;
    end
`else
    assign burst_hit = 1'b0;
`endif

    always_comb begin
        state_nxt    = state_q;
        grant_nxt    = grant_q;
        grant_id_nxt = grant_id_q;
        rr_ptr_nxt   = pick_ptr;
        case (state_q)
            GRANT: begin
                if (!req[grant_id_q] || burst_hit) begin
                    state_nxt = GAP;
                    grant_nxt = '0;
                end
            end
            default: begin
                grant_nxt = '0;
                if (pick_valid) begin
                    state_nxt           = GRANT;
                    grant_nxt[pick_idx] = 1'b1;
                    grant_id_nxt        = pick_idx;
                    rr_ptr_nxt          = pick_idx;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned i = 0; i < NREQ; i++)
            drop_sum = drop_sum + 9'(wr_en_in[i] & ~grant_q[i]);
        drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= LAST_IDX;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_nxt;
            grant_q    <= grant_nxt;
            grant_id_q <= grant_id_nxt;
            rr_ptr_q   <= rr_ptr_nxt;
            drop_cnt_q <= drop_nxt;
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = |grant_q;
    assign fb_we    = grant_q[grant_id_q] & wr_en_in[grant_id_q];
    assign fb_addr  = wr_addr_in[32'(grant_id_q)*ADDR_W +: ADDR_W];
    assign fb_data  = wr_data_in[32'(grant_id_q)*DATA_W +: DATA_W];
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_sprite_bus_arbiter.sv
// Directed self-checking bench for sprite_bus_arbiter (default or ARB_BURST_LIMIT_EN build).
module tb_sprite_bus_arbiter;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 12;

    logic                   clk = 1'b0;
    logic                   hard_reset;
    logic                   frame_start;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        wr_en_in;
    logic [NREQ*ADDR_W-1:0] wr_addr_in;
    logic [NREQ*DATA_W-1:0] wr_data_in;
    logic [NREQ-1:0]        grant;
    logic [1:0]             grant_id;
    logic                   busy;
    logic                   fb_we;
    logic [ADDR_W-1:0]      fb_addr;
    logic [DATA_W-1:0]      fb_data;
    logic [7:0]             drop_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    sprite_bus_arbiter #(
        .NREQ      (NREQ),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (64)
    ) dut (
        .clk         (clk),
        .hard_reset  (hard_reset),
        .frame_start (frame_start),
        .req         (req),
        .wr_en_in    (wr_en_in),
        .wr_addr_in  (wr_addr_in),
        .wr_data_in  (wr_data_in),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        hard_reset  = 1'b1;
        req         = '0;
        wr_en_in    = '0;
        frame_start = 1'b0;
        tick();
        hard_reset  = 1'b0;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int held;

    initial begin
        hard_reset  = 1'b1;
        frame_start = 1'b0;
        req         = '0;
        wr_en_in    = '0;
        wr_addr_in  = {17'h1D003, 17'h1C002, 17'h1B001, 17'h1A000};
        wr_data_in  = {12'hF33, 12'hA22, 12'h511, 12'h0C0};
        tick();
        tick();
        check_eq("rst_grant",    32'(grant),    32'h0);
        check_eq("rst_grant_id", 32'(grant_id), 32'h0);
        check_eq("rst_busy",     32'(busy),     32'h0);
        check_eq("rst_fb_we",    32'(fb_we),    32'h0);
        check_eq("rst_drop",     32'(drop_cnt), 32'h0);
        hard_reset = 1'b0;

        // First arbitration after reset
        req = 4'b0110;
        tick();
        check_eq("first_grant",    32'(grant),    32'b0010);
        check_eq("first_grant_id", 32'(grant_id), 32'd1);
        check_eq("first_busy",     32'(busy),     32'h1);
        req = 4'b0000;
        tick();
        check_eq("first_gap",      32'(grant),    32'h0);
        check_eq("first_id_hold",  32'(grant_id), 32'd1);
        tick();

        // Full rotation, each requester holds three cycles
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int c = 0; c < 3; c++) begin
                tick();
                check_eq($sformatf("rr%0d_c%0d", n, c), 32'(grant), 32'(1) << order[n]);
            end
            check_eq($sformatf("rr%0d_id", n), 32'(grant_id), 32'(order[n]));
            req[order[n]] = 1'b0;
            tick();
            check_eq($sformatf("rr%0d_gap", n), 32'(grant), 32'h0);
            check_eq($sformatf("rr%0d_gap_busy", n), 32'(busy), 32'h0);
            req[order[n]] = 1'b1;
        end
        req = '0;
        tick();
        tick();

        // frame_start mid-grant resets the pointer without aborting
        do_reset();
        req = 4'b0100;
        tick();
        check_eq("fs_grant2", 32'(grant), 32'b0100);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("fs_keep", 32'(grant), 32'b0100);
        req = 4'b1010;
        tick();
        check_eq("fs_gap", 32'(grant), 32'h0);
        tick();
        check_eq("fs_pick1", 32'(grant), 32'b0010);
        req = '0;
        tick();
        tick();

        // Write muxing and drop counting
        do_reset();
        req = 4'b0001;
        tick();
        check_eq("wr_grant0", 32'(grant), 32'b0001);
        wr_en_in = 4'b1101;
        #1;
        check_eq("wr_addr", 32'(fb_addr), 32'h1A000);
        check_eq("wr_data", 32'(fb_data), 32'h0C0);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("wr_we%0d", i), 32'(fb_we), 32'h1);
            tick();
        end
        wr_en_in = '0;
        check_eq("drop_20", 32'(drop_cnt), 32'd20);
        wr_en_in = 4'b1110;
        #1;
        check_eq("we_no_wr", 32'(fb_we), 32'h0);
        for (int i = 0; i < 80; i++)
            tick();
        wr_en_in = '0;
        check_eq("drop_sat", 32'(drop_cnt), 32'd255);

        // Asynchronous reset mid-grant
        wr_en_in = 4'b0001;
        #1;
        check_eq("pre_rst_we", 32'(fb_we), 32'h1);
        #2;
        hard_reset = 1'b1;
        #1;
        check_eq("mid_rst_grant", 32'(grant),    32'h0);
        check_eq("mid_rst_we",    32'(fb_we),    32'h0);
        check_eq("mid_rst_busy",  32'(busy),     32'h0);
        check_eq("mid_rst_drop",  32'(drop_cnt), 32'h0);
        wr_en_in = '0;
        req = 4'b1001;
        tick();
        check_eq("rst_held_grant", 32'(grant), 32'h0);
        hard_reset = 1'b0;
        tick();
        check_eq("post_rst_grant0", 32'(grant), 32'b0001);

        // One-cycle request still gets exactly one grant cycle
        req = '0;
        tick();
        tick();
        req = 4'b1000;
        tick();
        check_eq("pulse_grant", 32'(grant), 32'b1000);
        req = '0;
        tick();
        check_eq("pulse_gap", 32'(grant), 32'h0);
        tick();

        // Long hold by requester 0 with requester 3 raised at cycle 10
        do_reset();
        req = 4'b0001;
        tick();
        held = (grant == 4'b0001) ? 1 : 0;
        for (int c = 2; c <= 80; c++) begin
            if (c == 10)
                req = 4'b1001;
            tick();
            if (grant == 4'b0001)
                held++;
        end
`ifdef ARB_BURST_LIMIT_EN
        check_eq("burst_held", 32'(held),  32'd64);
        check_eq("burst_end",  32'(grant), 32'b1000);
`else
        check_eq("burst_held", 32'(held),  32'd80);
        check_eq("burst_end",  32'(grant), 32'b0001);
`endif
        req = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
